bram_port_arbiter: RTL and testbench

//  Shares one port of a dual_port_bram between two requesters (req0, req1) via round-robin arbitration.

---
 rtl/bram_port_arbiter_pkg.sv | 21 ++
 rtl/bram_port_arbiter_if.sv | 28 ++
 rtl/bram_port_arbiter_rr.sv | 29 ++
 rtl/bram_port_arbiter.sv | 123 ++++++++++++
 tb/tb_bram_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants and types for the BRAM port arbiter slice.
// The defaults describe a 64-bit x 1024 dual_port_bram port with a read latency of 3.
package zeus_bram_pkg;

  localparam int BRAM_READ_LATENCY = 3;
  localparam int BRAM_DATA_WIDTH   = 64;
  localparam int BRAM_DATA_DEPTH   = 1024;
  localparam int BRAM_ADDR_WIDTH   = $clog2(BRAM_DATA_DEPTH);

  typedef struct packed {
    logic                       we;
    logic [BRAM_ADDR_WIDTH-1:0] addr;
    logic [BRAM_DATA_WIDTH-1:0] wdata;
  } bram_req_t;

  typedef struct packed {
    logic valid;
    logic id;
  } rsp_tag_t;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// One requester's link to the arbiter: a request handshake and a read-return pulse.
// The master modport is the requester side; the slave modport is the arbiter side.
interface bram_port_arbiter_if
  import zeus_bram_pkg::*;
#(
  parameter int DATA_WIDTH = BRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH
);

  logic                  valid;
  logic                  ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/bram_port_arbiter_rr.sv
// Two-way round-robin grant. On a tie, the requester that was not granted last wins.
// The grant is combinational, and it is held low while reset is asserted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o = 2'b00;
    if (rst_n) begin
      if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
      else                gnt_o = req_i;
    end
  end

  assign last_d = (gnt_o != 2'b00) ? gnt_o[1] : last_q;

  // Resetting to 1 means req0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between two requesters. Winning accesses are registered onto the port.
// A {valid,id} tag pipeline follows each read through the BRAM latency and returns its data to the issuer.
module bram_port_arbiter
  import zeus_bram_pkg::*;
#(
  parameter int DATA_WIDTH   = BRAM_DATA_WIDTH,
  parameter int DATA_DEPTH   = BRAM_DATA_DEPTH,
  parameter int ADDR_WIDTH   = $clog2(DATA_DEPTH),
  parameter int READ_LATENCY = BRAM_READ_LATENCY
) (
  input  logic                               clk,
  input  logic                               rst_n,
  bram_port_arbiter_if.slave                 req0_if,
  bram_port_arbiter_if.slave                 req1_if,
  output logic                               bram_en_o,
  output logic                               bram_we_o,
  output logic [ADDR_WIDTH-1:0]              bram_addr_o,
  output logic [DATA_WIDTH-1:0]              bram_din_o,
  output logic                               bram_rst_o,
  input  logic [DATA_WIDTH-1:0]              bram_dout_i,
  output logic [$clog2(READ_LATENCY+2)-1:0]  rd_inflight_o
);

  localparam int TAG_STAGES = READ_LATENCY + 1;
  localparam int CNT_W      = $clog2(READ_LATENCY + 2);

  logic [1:0]            gnt;
  logic                  accept;
  logic                  sel;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  rd_accept;
  logic                  rsp_fire;

  logic                  en_q, en_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  rsp_tag_t              tag_q [TAG_STAGES];
  rsp_tag_t              tag_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({req1_if.valid, req0_if.valid}),
    .gnt_o (gnt)
  );

  assign req0_if.ready = gnt[0];
  assign req1_if.ready = gnt[1];

  assign accept    = |gnt;
  assign sel       = gnt[1];
  assign sel_we    = sel ? req1_if.we    : req0_if.we;
  assign sel_addr  = sel ? req1_if.addr  : req0_if.addr;
  assign sel_wdata = sel ? req1_if.wdata : req0_if.wdata;
  assign rd_accept = accept & ~sel_we;

  // addr/din keep their last value on idle cycles, so an idle port does not toggle its bus.
  always_comb begin
    en_d   = accept;
    we_d   = accept & sel_we;
    addr_d = accept ? sel_addr  : addr_q;
    din_d  = accept ? sel_wdata : din_q;
    tag_d.valid = rd_accept;
    tag_d.id    = sel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      en_q   <= en_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      din_q  <= din_d;
    end
  end

  // Stage k holds the tag of the access the BRAM has been working on for k cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAG_STAGES; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < TAG_STAGES; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign rsp_fire = tag_q[TAG_STAGES-1].valid & rst_n;

  assign req0_if.rsp_valid = rsp_fire & ~tag_q[TAG_STAGES-1].id;
  assign req1_if.rsp_valid = rsp_fire &  tag_q[TAG_STAGES-1].id;
  assign req0_if.rsp_rdata = req0_if.rsp_valid ? bram_dout_i : '0;
  assign req1_if.rsp_rdata = req1_if.rsp_valid ? bram_dout_i : '0;

  always_comb begin
    inflight_d = inflight_q;
    case ({rd_accept, rsp_fire})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) inflight_q <= '0;
    else        inflight_q <= inflight_d;
  end

  assign bram_en_o     = en_q;
  assign bram_we_o     = we_q;
  assign bram_addr_o   = addr_q;
  assign bram_din_o    = din_q;
  assign bram_rst_o    = ~rst_n;
  assign rd_inflight_o = inflight_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter against a read_first, latency-3 BRAM model.
// Expected read responses are queued per requester and checked by an independent monitor.
module tb_bram_port_arbiter;
  import zeus_bram_pkg::*;

  localparam int LAT = BRAM_READ_LATENCY;
  localparam int DW  = BRAM_DATA_WIDTH;
  localparam int AW  = BRAM_ADDR_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) r0 ();
  bram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) r1 ();

  logic          bram_en, bram_we, bram_rst;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din, bram_dout;
  logic [2:0]    rd_inflight;

  bram_port_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req0_if       (r0),
    .req1_if       (r1),
    .bram_en_o     (bram_en),
    .bram_we_o     (bram_we),
    .bram_addr_o   (bram_addr),
    .bram_din_o    (bram_din),
    .bram_rst_o    (bram_rst),
    .bram_dout_i   (bram_dout),
    .rd_inflight_o (rd_inflight)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Read_first BRAM model: the read sees the word before a same-cycle write, three register stages.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] p0, p1;
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= 64'hC0DE_0000 + 64'(i);
      mem[5] <= 64'hA5;
    end else if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      p0 <= mem[bram_addr];
    end
    p1        <= p0;
    bram_dout <= p1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  task automatic push(input int id, input int at, input logic [DW-1:0] d);
    exp_t e;
    e.cyc  = at;
    e.data = d;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic sb(input int id, input logic v, input logic [DW-1:0] d);
    exp_t e;
    if (v) begin
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
        checks++;
        failures++;
        $display("FAIL rsp%0d_unexpected actual=pulse required=none cyc=%0d", id, cyc);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("rsp%0d_data", id), d, e.data);
        chk($sformatf("rsp%0d_cycle", id), 64'(cyc), 64'(e.cyc));
      end
    end else begin
      chk($sformatf("rsp%0d_idle_zero", id), d, '0);
    end
  endtask

  logic          mon_en = 1'b0;
  logic          prev_acc = 1'b0;
  logic          prev_we = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_din = '0;
  int            peak = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("one_ready", 64'(r0.ready & r1.ready), 64'd0);
      chk("issue_en", 64'(bram_en), 64'(prev_acc));
      if (prev_acc) begin
        chk("issue_we", 64'(bram_we), 64'(prev_we));
        chk("issue_addr", 64'(bram_addr), 64'(prev_addr));
        if (prev_we) chk("issue_din", bram_din, prev_din);
      end else begin
        chk("idle_we", 64'(bram_we), 64'd0);
      end
      sb(0, r0.rsp_valid, r0.rsp_rdata);
      sb(1, r1.rsp_valid, r1.rsp_rdata);
      if (int'(rd_inflight) > peak) peak = int'(rd_inflight);
      chk("inflight_bound", 64'(int'(rd_inflight) > LAT + 1), 64'd0);
      prev_acc  = (r0.valid & r0.ready) | (r1.valid & r1.ready);
      prev_we   = r1.ready ? r1.we    : r0.we;
      prev_addr = r1.ready ? r1.addr  : r0.addr;
      prev_din  = r1.ready ? r1.wdata : r0.wdata;
    end
  end

  task automatic drive(input int id, input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (id == 0) begin r0.valid = v; r0.we = we; r0.addr = a; r0.wdata = d; end
    else         begin r1.valid = v; r1.we = we; r1.addr = a; r1.wdata = d; end
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? r0.ready : r1.ready;
  endfunction

  // Called just after a rising edge; returns just after the rising edge that follows the accept.
  task automatic issue(input int id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp);
    int n = 0;
    drive(id, 1'b1, we, a, d);
    @(negedge clk);
    while (!rdy(id) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(id)) begin
      checks++;
      failures++;
      $display("FAIL issue%0d_timeout actual=no_ready required=ready cyc=%0d", id, cyc);
    end else if (!we) begin
      push(id, cyc + 1 + LAT, exp);
    end
    @(posedge clk); #1;
    drive(id, 1'b0, 1'b0, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    idle(3);

    // Reset values, sampled while reset is still held
    r0.valid = 1'b1;
    r1.valid = 1'b1;
    @(negedge clk);
    chk("rst_ready0", 64'(r0.ready), 64'd0);
    chk("rst_ready1", 64'(r1.ready), 64'd0);
    chk("rst_bram_en", 64'(bram_en), 64'd0);
    chk("rst_bram_we", 64'(bram_we), 64'd0);
    chk("rst_bram_rst", 64'(bram_rst), 64'd1);
    chk("rst_inflight", 64'(rd_inflight), 64'd0);
    chk("rst_rsp0", 64'(r0.rsp_valid), 64'd0);
    chk("rst_rsp1", 64'(r1.rsp_valid), 64'd0);
    @(posedge clk); #1;
    r0.valid = 1'b0;
    r1.valid = 1'b0;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // 1: single read from req0
    issue(0, 1'b0, 10'd5, '0, 64'hA5);
    chk("run_bram_rst", 64'(bram_rst), 64'd0);
    idle(6);

    // 6: only req1 valid for 5 cycles
    drive(1, 1'b1, 1'b0, 10'd30, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("solo_ready1", 64'(r1.ready), 64'd1);
      chk("solo_ready0", 64'(r0.ready), 64'd0);
      if (r1.ready) push(1, cyc + 1 + LAT, 64'hC0DE_001E);
      @(posedge clk); #1;
    end
    drive(1, 1'b0, 1'b0, 10'd30, '0);
    idle(6);

    // 2: both valid for 6 cycles; last grant was req1
    drive(0, 1'b1, 1'b0, 10'd20, '0);
    drive(1, 1'b1, 1'b0, 10'd21, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("tie_ready0", 64'(r0.ready), 64'(i % 2 == 0));
      chk("tie_ready1", 64'(r1.ready), 64'(i % 2 == 1));
      if (r0.ready) push(0, cyc + 1 + LAT, 64'hC0DE_0014);
      if (r1.ready) push(1, cyc + 1 + LAT, 64'hC0DE_0015);
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 1'b0, 10'd20, '0);
    drive(1, 1'b0, 1'b0, 10'd21, '0);
    idle(8);

    // 3: write then read of the same address on the following cycle
    issue(1, 1'b1, 10'd9, 64'h1234, '0);
    issue(0, 1'b0, 10'd9, '0, 64'h1234);
    idle(8);

    // 4: four back-to-back reads, alternating requesters
    peak = 0;
    issue(0, 1'b0, 10'd50, '0, 64'hC0DE_0032);
    issue(1, 1'b0, 10'd51, '0, 64'hC0DE_0033);
    issue(0, 1'b0, 10'd52, '0, 64'hC0DE_0034);
    issue(1, 1'b0, 10'd53, '0, 64'hC0DE_0035);
    idle(8);
    chk("b2b_peak", 64'(peak), 64'd4);
    chk("b2b_drain", 64'(rd_inflight), 64'd0);

    // 5: reset pulse with two reads in flight; their responses must never appear
    issue(0, 1'b0, 10'd40, '0, 64'hC0DE_0028);
    issue(1, 1'b0, 10'd41, '0, 64'hC0DE_0029);
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b0, 10'd42, '0);
    drive(1, 1'b1, 1'b0, 10'd43, '0);
    @(negedge clk);
    chk("mid_rst_ready0", 64'(r0.ready), 64'd0);
    chk("mid_rst_ready1", 64'(r1.ready), 64'd0);
    chk("mid_rst_bram_rst", 64'(bram_rst), 64'd1);
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_inflight", 64'(rd_inflight), 64'd0);
    chk("post_rst_tie0", 64'(r0.ready), 64'd1);
    chk("post_rst_tie1", 64'(r1.ready), 64'd0);
    if (r0.ready) push(0, cyc + 1 + LAT, 64'hC0DE_002A);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 10'd42, '0);
    drive(1, 1'b0, 1'b0, 10'd43, '0);
    idle(10);

    chk("final_q0_empty", 64'(q0.size()), 64'd0);
    chk("final_q1_empty", 64'(q1.size()), 64'd0);
    chk("final_inflight", 64'(rd_inflight), 64'd0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
